// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider and its CLA subtractor.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int CLA_GROUP     = 4;
  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/seq_divider_cla_sub.sv
// Carry-lookahead subtractor a + ~b + 1, built from 4-bit generate/propagate groups
// whose group carries ripple from a carry-in of 1.
module cla_pre_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] g_o,
  output logic [3:0] p_o
);
  assign g_o = a_i & b_i;
  assign p_o = a_i ^ b_i;
endmodule

module cla_logic_4 (
  input  logic [3:0] g_i,
  input  logic [3:0] p_i,
  input  logic       c_i,
  output logic [3:0] c_o,
  output logic       co_o
);
  assign c_o[0] = c_i;
  assign c_o[1] = g_i[0] | (p_i[0] & c_i);
  assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
  assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                | (p_i[2] & p_i[1] & p_i[0] & c_i);
  assign co_o   = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
                | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & c_i);
endmodule

module cla_sub
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             cout_o
);
  localparam int NG = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] b_n;
  logic [NG:0]      gc;

  assign b_n   = ~b_i;
  assign gc[0] = 1'b1;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [3:0] g, p, c;

    cla_pre_4 u_pre (
      .a_i (a_i[k*CLA_GROUP +: CLA_GROUP]),
      .b_i (b_n[k*CLA_GROUP +: CLA_GROUP]),
      .g_o (g),
      .p_o (p)
    );

    cla_logic_4 u_logic (
      .g_i  (g),
      .p_i  (p),
      .c_i  (gc[k]),
      .c_o  (c),
      .co_o (gc[k+1])
    );

    assign diff_o[k*CLA_GROUP +: CLA_GROUP] = p ^ c;
  end

  assign cout_o = gc[NG];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional DIVIDER_ZERO_DETECT_EN short-circuits a zero divisor through the ZERO state.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] shifted, diff, rem_step, quo_step;
  logic             cout, ge;

  assign shifted  = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  // A set top bit means the true partial remainder exceeds WIDTH bits, so it is >= divisor.
  assign ge       = cout | rem_q[WIDTH-1];
  assign rem_step = ge ? diff : shifted;
  assign quo_step = {dvd_q[WIDTH-2:0], ge};

  cla_sub #(.WIDTH(WIDTH)) u_sub (
    .a_i    (shifted),
    .b_i    (dvs_q),
    .diff_o (diff),
    .cout_o (cout)
  );

`ifdef DIVIDER_ZERO_DETECT_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    cnt_d   = cnt_q;
`ifdef DIVIDER_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          dvd_d = i_dividend;
          dvs_d = i_divisor;
          rem_d = '0;
          cnt_d = '0;
`ifdef DIVIDER_ZERO_DETECT_EN
          dbz_d   = 1'b0;
          state_d = (i_divisor == '0) ? ZERO : RUN;
`else
          state_d = RUN;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d = rem_step;
        dvd_d = quo_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          quo_d   = quo_step;
          remo_d  = rem_step;
        end
      end
`ifdef DIVIDER_ZERO_DETECT_EN
      ZERO: begin
        quo_d   = '1;
        remo_d  = dvd_q;
        dbz_d   = 1'b1;
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DIVIDER_ZERO_DETECT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) dbz_q <= 1'b0;
    else          dbz_q <= dbz_d;
  end
  assign o_div_by_zero = dbz_q;
  assign o_busy        = (state_q == RUN) || (state_q == ZERO);
`else
  assign o_div_by_zero = 1'b0;
  assign o_busy        = (state_q == RUN);
`endif

  assign o_done      = (state_q == DONE);
  assign o_quotient  = quo_q;
  assign o_remainder = remo_q;
endmodule
